// File: rtl/dpll_pkg.sv
// Shared DPLL constants and types: NCO widths, FCW limits and LFSR definition.
package dpll_pkg;

    localparam int unsigned ACC_W    = 24;
    localparam int unsigned FCW_W    = 24;
    localparam int unsigned PHASE_W  = 8;

    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [FCW_W-1:0] fcw_t;

    localparam fcw_t FCW_INIT = 24'h100000;
    localparam fcw_t FCW_MIN  = 24'h010000;
    localparam fcw_t FCW_MAX  = 24'h400000;

    // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form
    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int unsigned DITHER_W  = 4;

endpackage

// File: rtl/dpll_lfsr16.sv
// 16-bit Galois LFSR; advances on each enabled cycle, exposes its low bits as dither.
module dpll_lfsr16
    import dpll_pkg::*;
#(
    parameter int unsigned OUT_W = DITHER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_dither
);

    logic [LFSR_W-1:0] r_state;

    // Shift right, fold taps in when the outgoing bit is set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LFSR_SEED;
        end else if (i_en) begin
            r_state <= {1'b0, r_state[LFSR_W-1:1]} ^ (r_state[0] ? LFSR_TAPS : '0);
        end
    end

    assign o_dither = r_state[OUT_W-1:0];

endmodule

// File: rtl/dpll_nco.sv
// Phase-accumulator NCO for the DPLL. New FCWs are clamped, held pending and
// only take effect at an accumulator wrap so clk_out never glitches.
// Optional build macro: DPLL_NCO_DITHER_EN adds LFSR dither to the accumulator LSBs.
module dpll_nco #(
    parameter int unsigned       ACC_W    = dpll_pkg::ACC_W,
    parameter int unsigned       FCW_W    = dpll_pkg::FCW_W,
    parameter int unsigned       PHASE_W  = dpll_pkg::PHASE_W,
    parameter logic [FCW_W-1:0]  FCW_INIT = FCW_W'(dpll_pkg::FCW_INIT),
    parameter logic [FCW_W-1:0]  FCW_MIN  = FCW_W'(dpll_pkg::FCW_MIN),
    parameter logic [FCW_W-1:0]  FCW_MAX  = FCW_W'(dpll_pkg::FCW_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [FCW_W-1:0]   fcw_in,
    input  logic               fcw_valid,
    output logic               fcw_ack,
    output logic [FCW_W-1:0]   fcw_active,
    output logic               clk_out,
    output logic               edge_pulse,
    output logic [PHASE_W-1:0] phase_out
);

    import dpll_pkg::*;

    logic [ACC_W-1:0]   r_acc;
    logic [FCW_W-1:0]   r_fcw_active;
    logic [FCW_W-1:0]   r_pending;
    logic               r_pend_flag;
    logic               r_clk_out;
    logic               r_edge_pulse;
    logic               r_fcw_ack;
    logic [PHASE_W-1:0] r_phase;

    logic [ACC_W:0]     w_sum;
    logic [FCW_W-1:0]   w_fcw_clamped;
    logic               w_wrap;
    logic               w_apply;

`ifdef DPLL_NCO_DITHER_EN
    logic [DITHER_W-1:0] w_dither;

    dpll_lfsr16 #(
        .OUT_W (DITHER_W)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .i_en     (en),
        .o_dither (w_dither)
    );

    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(r_fcw_active) + (ACC_W+1)'(w_dither);
`else
    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(r_fcw_active);
`endif

    // Clamp incoming FCW and detect wrap / apply conditions
    always_comb begin
        w_fcw_clamped = fcw_in;
        if (fcw_in < FCW_MIN) begin
            w_fcw_clamped = FCW_MIN;
        end else if (fcw_in > FCW_MAX) begin
            w_fcw_clamped = FCW_MAX;
        end
        w_wrap  = en & w_sum[ACC_W];
        w_apply = w_wrap & r_pend_flag;
    end

    // Accumulator, FCW handover and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_fcw_active <= FCW_INIT;
            r_pending    <= '0;
            r_pend_flag  <= 1'b0;
            r_clk_out    <= 1'b0;
            r_edge_pulse <= 1'b0;
            r_fcw_ack    <= 1'b0;
            r_phase      <= '0;
        end else begin
            if (en) begin
                r_acc <= w_sum[ACC_W-1:0];
            end
            r_clk_out    <= r_acc[ACC_W-1];
            r_edge_pulse <= r_acc[ACC_W-1] & ~r_clk_out;
            r_phase      <= r_acc[ACC_W-1 -: PHASE_W];
            r_fcw_ack    <= w_apply;
            if (w_apply) begin
                r_fcw_active <= r_pending;
                r_pend_flag  <= 1'b0;
            end
            // A strobe in the apply cycle stays pending for the next wrap
            if (fcw_valid) begin
                r_pending   <= w_fcw_clamped;
                r_pend_flag <= 1'b1;
            end
        end
    end

    assign fcw_ack    = r_fcw_ack;
    assign fcw_active = r_fcw_active;
    assign clk_out    = r_clk_out;
    assign edge_pulse = r_edge_pulse;
    assign phase_out  = r_phase;

endmodule

// File: tb/tb_dpll_nco.sv
// Self-checking bench for dpll_nco (default build, no dither).
module tb_dpll_nco;

    localparam longint MODV = 64'd16777216;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [23:0] fcw_in = '0;
    logic        fcw_valid = 1'b0;
    logic        fcw_ack;
    logic [23:0] fcw_active;
    logic        clk_out;
    logic        edge_pulse;
    logic [7:0]  phase_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dpll_nco dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fcw_in     (fcw_in),
        .fcw_valid  (fcw_valid),
        .fcw_ack    (fcw_ack),
        .fcw_active (fcw_active),
        .clk_out    (clk_out),
        .edge_pulse (edge_pulse),
        .phase_out  (phase_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_acc, m_fcw, m_pend, m_next;
    bit     m_pflag, m_valid = 0, m_apply;
    logic   e_clk, e_edge, e_ack;
    logic [7:0]  e_phase;
    logic [23:0] e_active;

    function automatic longint clampv(input longint v);
        if (v < 64'h010000) return 64'h010000;
        if (v > 64'h400000) return 64'h400000;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_acc = 0; m_fcw = 64'h100000; m_pend = 0; m_pflag = 0; m_valid = 1;
            e_clk = 0; e_edge = 0; e_ack = 0; e_phase = 0; e_active = 24'h100000;
        end else begin
            // outputs show the phase held before this edge
            e_edge  = (m_acc >= MODV/2) && !e_clk;
            e_clk   = (m_acc >= MODV/2);
            e_phase = 8'(m_acc / 65536);
            // phase advances with the old FCW; overflow of a full turn is a wrap
            m_next  = en ? m_acc + m_fcw : m_acc;
            m_apply = en && (m_next >= MODV) && m_pflag;
            m_acc   = m_next % MODV;
            e_ack   = m_apply;
            if (m_apply) begin
                m_fcw = m_pend;
                m_pflag = 0;
            end
            if (fcw_valid) begin
                m_pend = clampv(longint'(fcw_in));
                m_pflag = 1;
            end
            e_active = 24'(m_fcw);
        end
    end

    // Compare every cycle once reset has been seen
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_clk_out", 32'(clk_out), 32'(e_clk));
            chk("m_edge_pulse", 32'(edge_pulse), 32'(e_edge));
            chk("m_fcw_ack", 32'(fcw_ack), 32'(e_ack));
            chk("m_phase_out", 32'(phase_out), 32'(e_phase));
            chk("m_fcw_active", 32'(fcw_active), 32'(e_active));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [23:0] v);
        fcw_in = v;
        fcw_valid = 1'b1;
        step(1);
        fcw_valid = 1'b0;
    endtask

    // which: 0 = edge_pulse, 1 = fcw_ack; returns cycles stepped
    task automatic wait_ev(input string name, input int which, input int maxc, output int cyc);
        logic s;
        cyc = 0;
        do begin
            step(1);
            cyc++;
            s = (which == 0) ? edge_pulse : fcw_ack;
        end while (!s && cyc < maxc);
        chk(name, 32'(s), 32'd1);
    endtask

    task automatic measure(input string name, input int exp, input int maxc);
        int c;
        wait_ev({name, "_e1"}, 0, maxc, c);
        wait_ev({name, "_e2"}, 0, maxc, c);
        wait_ev({name, "_e3"}, 0, maxc, c);
        chk(name, 32'(c), 32'(exp));
    endtask

    task automatic high_count(input string name, input int len, input int exp);
        int hi = 0;
        for (int i = 0; i < len; i++) begin
            hi += int'(clk_out);
            step(1);
        end
        chk(name, 32'(hi), 32'(exp));
    endtask

    task automatic count_acks(input string name, input int len);
        int a = 0;
        for (int i = 0; i < len; i++) begin
            step(1);
            a += int'(fcw_ack);
        end
        chk(name, 32'(a), 32'd0);
    endtask

    initial begin
        int c;
        logic [7:0] p_hold;
        logic       c_hold;

        step(2);
        rst = 1'b0;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_phase", 32'(phase_out), 32'd0);
        chk("rst_edge", 32'(edge_pulse), 32'd0);
        chk("rst_ack", 32'(fcw_ack), 32'd0);
        chk("rst_fcw_active", 32'(fcw_active), 32'h100000);

        // FCW_INIT: 16-cycle period, 8 high
        en = 1'b1;
        measure("period16", 16, 40);
        high_count("high16", 16, 8);

        // mid-period update waits for the wrap
        step(3);
        strobe(24'h200000);
        chk("hold_before_wrap", 32'(fcw_active), 32'h100000);
        wait_ev("ack_200000", 1, 40, c);
        chk("active_200000", 32'(fcw_active), 32'h200000);
        step(1);
        chk("ack_one_cycle", 32'(fcw_ack), 32'd0);
        measure("period8", 8, 40);

        // clamps
        strobe(24'h000100);
        wait_ev("ack_min", 1, 40, c);
        chk("active_min", 32'(fcw_active), 32'h010000);
        measure("period256", 256, 600);
        strobe(24'hFFFFFF);
        wait_ev("ack_max", 1, 600, c);
        chk("active_max", 32'(fcw_active), 32'h400000);
        measure("period4", 4, 20);
        high_count("high4", 4, 2);

        // latest strobe wins: start just after a wrap so both land before the next
        strobe(24'h010000);
        wait_ev("ack_slow", 1, 20, c);
        strobe(24'h080000);
        strobe(24'h200000);
        wait_ev("ack_latest", 1, 600, c);
        chk("active_latest", 32'(fcw_active), 32'h200000);
        count_acks("single_ack", 24);

        // strobe in an applying wrap cycle is applied one wrap later
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        strobe(24'h180000);
        step(14);
        strobe(24'h080000);
        chk("coinc_ack", 32'(fcw_ack), 32'd1);
        chk("coinc_active", 32'(fcw_active), 32'h180000);
        wait_ev("coinc_ack2", 1, 40, c);
        chk("coinc_active2", 32'(fcw_active), 32'h080000);

        // enable low: phase frozen, pending not applied
        step(3);
        en = 1'b0;
        strobe(24'h300000);
        p_hold = phase_out;
        c_hold = clk_out;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("frz_phase", 32'(phase_out), 32'(p_hold));
            chk("frz_clk", 32'(clk_out), 32'(c_hold));
            chk("frz_ack", 32'(fcw_ack), 32'd0);
        end
        en = 1'b1;
        wait_ev("resume_ack", 1, 40, c);
        chk("resume_active", 32'(fcw_active), 32'h300000);

        // reset with pending FCW while clk_out is high
        wait_ev("pre_rst_edge", 0, 40, c);
        strobe(24'h0C0000);
        chk("pre_rst_clk_high", 32'(clk_out), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("post_rst_clk", 32'(clk_out), 32'd0);
        chk("post_rst_active", 32'(fcw_active), 32'h100000);
        chk("post_rst_phase", 32'(phase_out), 32'd0);
        count_acks("post_rst_no_ack", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpll_nco.md
Name: dpll_nco

Overview:
- Digitally controlled oscillator for the DPLL. Phase-accumulator NCO driven by the frequency control word (FCW) from the loop filter.
- Produces the recovered square-wave clock that feeds the global-buffer cell.
- Also provides the accumulator phase and an edge strobe to the phase detector.
- Supports glitch-free FCW updates: a new FCW is applied only at an accumulator wrap.

Parameters:
- ACC_W, 24: accumulator width in bits.
- FCW_W, 24: FCW width in bits. Must be ≤ ACC_W.
- PHASE_W, 8: width of `phase_out`, taken from the accumulator MSBs.
- FCW_INIT, 24'h100000: active FCW after reset.
- FCW_MIN, 24'h010000: lower clamp applied to incoming FCW.
- FCW_MAX, 24'h400000: upper clamp applied to incoming FCW.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  accumulate enable. When low, the accumulator holds.
- `fcw_in`  in  FCW_W  new frequency control word, unsigned.
- `fcw_valid`  in  1  one-cycle strobe that captures `fcw_in`.
- `fcw_ack`  out  1  one-cycle pulse in the cycle a pending FCW becomes active.
- `fcw_active`  out  FCW_W  FCW currently being accumulated.
- `clk_out`  out  1  registered accumulator MSB. Routed to the global-buffer input.
- `edge_pulse`  out  1  one-cycle pulse on each 0→1 transition of `clk_out`.
- `phase_out`  out  PHASE_W  registered accumulator bits [ACC_W-1 : ACC_W-PHASE_W].

Behaviour:
- Reset (`rst`=1 at a `clk` edge) sets:
  - acc=0, fcw_active=FCW_INIT, pending=0, pend_flag=0;
  - clk_out=0, edge_pulse=0, fcw_ack=0, phase_out=0.
- Reset mid-operation discards any pending FCW and restarts phase at 0.
- Accumulate: when `en`=1, acc_next = (acc + zero-extended fcw_active) mod 2^ACC_W. wrap = carry out of that add.
- When `en`=0, acc holds, no wrap occurs, and the pending FCW stays pending.
- Output latency:
  - `clk_out` and `phase_out` are registered from acc, one cycle after acc updates, i.e. two cycles after the enable edge.
  - `edge_pulse` is asserted in the cycle where `clk_out` goes 0→1.
- FCW capture:
  - On `fcw_valid`=1, the clamped value min(max(`fcw_in`, FCW_MIN), FCW_MAX) is written to pending and pend_flag is set.
  - A new `fcw_valid` while pend_flag=1 overwrites pending (latest wins). No ack is issued for the overwritten value.
- FCW apply:
  - In a cycle with wrap=1 and pend_flag=1 (pend_flag being the value at the start of the cycle): fcw_active←pending, pend_flag cleared, `fcw_ack`=1 for exactly one cycle.
  - The wrap-cycle add still uses the old fcw_active.
  - If `fcw_valid` coincides with an applying wrap, the new value becomes pending, pend_flag stays 1, and it is applied at the next wrap.
- Period: clk_out period = 2^ACC_W / fcw_active cycles, average. Duty cycle is 50% ±1 cycle.
- FCW_MAX ≤ 2^(ACC_W-2) guarantees at least 4 cycles per period.
- No overflow of fcw_active is possible; clamping is unsigned.

Optional Feature:
- Macro `DPLL_NCO_DITHER_EN`.
- Defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances each enabled cycle.
  - Its low 4 bits are added to the lower accumulator bits each enabled cycle, spreading spurs.
  - The wrap rule is unchanged; average frequency shifts by the mean dither (+7.5 LSB/cycle), which the loop absorbs.
- Undefined: no LFSR logic. Behaviour exactly as above.

Decomposition:
- Package `dpll_pkg`:
  - ACC_W, FCW_W and PHASE_W defaults;
  - typedefs fcw_t and acc_t;
  - FCW_INIT, FCW_MIN and FCW_MAX constants;
  - LFSR seed and taps constants, shared with the phase detector and loop filter.
- One natural sub-module, `dpll_lfsr16`, instantiated only under `DPLL_NCO_DITHER_EN`.

Test Plan:
- Reset → all outputs 0 and fcw_active=24'h100000. With `en`=1, clk_out is periodic at 16 cycles: 8 high, 8 low. edge_pulse fires every 16 cycles.
- fcw_in=24'h200000 strobed mid-period → no change until the next wrap. At that wrap fcw_ack=1 for one cycle, and subsequent periods are 8 cycles.
- fcw_in=24'h000100 → fcw_active becomes 24'h010000 (256-cycle period). fcw_in=24'hFFFFFF → fcw_active becomes 24'h400000 (4-cycle period).
- Two strobes before a wrap (24'h080000, then 24'h200000) → a single fcw_ack, with fcw_active=24'h200000. A strobe coinciding with a wrap is applied one wrap later.
- `en`=0 for 5 cycles mid-period → clk_out, phase_out and acc frozen, and the pending FCW is not applied. Resuming continues from the same phase.
- `rst` asserted for 1 cycle with a pending FCW and clk_out=1 → next cycle: clk_out=0, fcw_active=FCW_INIT, no fcw_ack afterwards.
